// File: rtl/arbitro_pkg.sv
// Shared definitions for the two-requester arbitrated subtractor: default width,
// result-slot state type, requester index type and the round-robin pick helper.
package arbitro_pkg;

  localparam int W_DEFAULT = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef logic req_idx_t;

  // With both requesters valid the one not granted last wins; otherwise the lone valid one.
  function automatic req_idx_t rr_pick(input logic v0, input logic v1, input req_idx_t last);
    req_idx_t pick;
    if (v0 && v1) begin
      pick = ~last;
    end else if (v1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/arbitro_restador_if.sv
// Handshake bundle between two requesters, the arbitrated subtractor and its consumer.
interface arbitro_restador_if #(parameter int W = arbitro_pkg::W_DEFAULT) ();

  logic         req0_valid;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_ready;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_neg;
  logic         res_id;
  logic         res_ready;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_neg, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_neg, res_id
  );

endinterface

// File: rtl/arbitro_restador_restador.sv
// Plain W-bit wrapping subtractor shared by both requesters.
module restador #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff
);

  assign diff = a - b;

endmodule

// File: rtl/arbitro_restador.sv
// Round-robin arbiter feeding one shared subtractor into a single result slot;
// the slot can drain and refill in the same cycle for one result per clock.
module arbitro_restador
  import arbitro_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  arbitro_restador_if.slave  bus
);

  state_t       state_r;
  req_idx_t     last_r;
  logic [W-1:0] res_data_r;
  logic         res_neg_r;
  logic         res_id_r;

  logic         grant_any_s;
  req_idx_t     grant_idx_s;
  logic         slot_free_s;
  logic         accept_s;
  logic [W-1:0] op_a_s;
  logic [W-1:0] op_b_s;
  logic [W-1:0] diff_s;
  logic         neg_s;

  // Grant selection, slot availability and the operand mux in front of the subtractor.
  always_comb begin
    grant_any_s = bus.req0_valid | bus.req1_valid;
    grant_idx_s = rr_pick(bus.req0_valid, bus.req1_valid, last_r);
    slot_free_s = (state_r == EMPTY) | bus.res_ready;
    accept_s    = rst_n & slot_free_s & grant_any_s;
    if (grant_idx_s == 1'b1) begin
      op_a_s = bus.req1_a;
      op_b_s = bus.req1_b;
    end else begin
      op_a_s = bus.req0_a;
      op_b_s = bus.req0_b;
    end
    neg_s = (op_a_s < op_b_s);
  end

  restador #(.W(W)) u_restador (
    .a    (op_a_s),
    .b    (op_b_s),
    .diff (diff_s)
  );

  assign bus.req0_ready = accept_s & (grant_idx_s == 1'b0);
  assign bus.req1_ready = accept_s & (grant_idx_s == 1'b1);
  assign bus.res_valid  = (state_r == FULL);
  assign bus.res_data   = res_data_r;
  assign bus.res_neg    = res_neg_r;
  assign bus.res_id     = res_id_r;

  // Result slot FSM; pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      last_r     <= 1'b1;
      res_data_r <= {W{1'b0}};
      res_neg_r  <= 1'b0;
      res_id_r   <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r    <= FULL;
            last_r     <= grant_idx_s;
            res_data_r <= diff_s;
            res_neg_r  <= neg_s;
            res_id_r   <= grant_idx_s;
          end else begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          if (accept_s) begin
            state_r    <= FULL;
            last_r     <= grant_idx_s;
            res_data_r <= diff_s;
            res_neg_r  <= neg_s;
            res_id_r   <= grant_idx_s;
          end else if (bus.res_ready) begin
            state_r <= EMPTY;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_restador.sv
// Directed bench for arbitro_restador at W=3: table of per-cycle vectors plus a
// hand-written reset-while-full sequence.
module tb_arbitro_restador;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  arbitro_restador_if #(.W(3)) bus ();

  arbitro_restador #(.W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [2:0] a0;
    logic [2:0] b0;
    logic       v1;
    logic [2:0] a1;
    logic [2:0] b1;
    logic       rr;
    logic       e_r0;
    logic       e_r1;
    logic       e_val;
    logic [2:0] e_data;
    logic       e_neg;
    logic       e_id;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic v0, input logic [2:0] a0, input logic [2:0] b0,
                              input logic v1, input logic [2:0] a1, input logic [2:0] b1,
                              input logic rr, input logic e_r0, input logic e_r1,
                              input logic e_val, input logic [2:0] e_data,
                              input logic e_neg, input logic e_id);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1;
    v.rr = rr; v.e_r0 = e_r0; v.e_r1 = e_r1;
    v.e_val = e_val; v.e_data = e_data; v.e_neg = e_neg; v.e_id = e_id;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [2:0] a0, input logic [2:0] b0,
                       input logic v1, input logic [2:0] a1, input logic [2:0] b1,
                       input logic rr);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    bus.res_ready  = rr;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);

    //             v0    a0    b0    v1    a1    b1    rr    r0    r1    val   data  neg   id
    tbl[0]  = mk(1'b1, 3'd5, 3'd4, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
    tbl[2]  = mk(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 3'd6, 3'd2, 1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 3'd6, 3'd2, 1'b1, 3'd1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1);
    tbl[5]  = mk(1'b1, 3'd6, 3'd2, 1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 3'd6, 3'd2, 1'b1, 3'd1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1);
    tbl[7]  = mk(1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1);
    tbl[9]  = mk(1'b1, 3'd4, 3'd2, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 3'd4, 3'd2, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 3'd4, 3'd2, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 3'd4, 3'd2, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 3'd4, 3'd2, 1'b1, 3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1);
    tbl[14] = mk(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    tbl[15] = mk(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Reset state with both requesters asking: nothing may be accepted.
    repeat (2) @(negedge clk);
    drive(1'b1, 3'd5, 3'd4, 1'b1, 3'd0, 3'd1, 1'b1);
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_neg", bus.res_neg, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
      #1;
      chk($sformatf("v%0d_req0_ready", i), bus.req0_ready, tbl[i].e_r0);
      chk($sformatf("v%0d_req1_ready", i), bus.req1_ready, tbl[i].e_r1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_res_valid", i), bus.res_valid, tbl[i].e_val);
      if (tbl[i].e_val) begin
        chk($sformatf("v%0d_res_data", i), bus.res_data, tbl[i].e_data);
        chk($sformatf("v%0d_res_neg", i), bus.res_neg, tbl[i].e_neg);
        chk($sformatf("v%0d_res_id", i), bus.res_id, tbl[i].e_id);
      end
    end

    // Reset while FULL discards the result; pointer returns to favour requester 0.
    @(negedge clk);
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 3'd1, 1'b1);
    @(posedge clk);
    #1;
    chk("pre_reset_id", bus.res_id, 1);
    @(negedge clk);
    drive(1'b1, 3'd5, 3'd4, 1'b0, 3'd0, 3'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("full_before_reset", bus.res_valid, 1);
    chk("full_before_reset_data", bus.res_data, 1);
    @(negedge clk);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_res_data", bus.res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd2, 3'd3, 1'b1, 3'd6, 3'd1, 1'b1);
    #1;
    chk("postrst_res_valid", bus.res_valid, 0);
    chk("postrst_req0_ready", bus.req0_ready, 1);
    chk("postrst_req1_ready", bus.req1_ready, 0);
    @(posedge clk);
    #1;
    chk("postrst_res_id", bus.res_id, 0);
    chk("postrst_res_data", bus.res_data, 7);
    chk("postrst_res_neg", bus.res_neg, 1);
    @(negedge clk);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
